// File: rtl/cpu_mem_responder_pkg.sv
// Shared types and address helpers for the CPU memory responder.
// Word size, FSM states and the word-index / range-check functions live here.
package cpu_mem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Word index of a byte address for an array of 2**aw words.
  function automatic logic [WORD_W-1:0] word_index(input logic [WORD_W-1:0] addr,
                                                   input int aw);
    logic [WORD_W-1:0] mask;
    mask = (32'd1 << aw) - 32'd1;
    return (addr >> 2) & mask;
  endfunction

  // Aligned and inside the 2**aw word array.
  function automatic logic in_range(input logic [WORD_W-1:0] addr, input int aw);
    return ((addr >> (aw + 2)) == '0) && (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/cpu_mem_responder_if.sv
// CPU-side bus of the memory responder: instruction port, data port and boot-load stream.
// master = CPU/loader side, slave = memory responder.
interface cpu_mem_if;
  import cpu_mem_pkg::*;

  logic              IM_enable;
  logic [WORD_W-1:0] IM_address;
  logic              IM_write;
  logic [WORD_W-1:0] IM_out;

  logic              DM_enable;
  logic              DM_write;
  logic [WORD_W-1:0] DM_address;
  logic [WORD_W-1:0] DM_in;
  logic [WORD_W-1:0] DM_out;

  logic              ld_valid;
  logic [WORD_W-1:0] ld_data;
  logic              ld_done;
  logic              ld_ready;

  modport master (
    output IM_enable, IM_address, IM_write,
    output DM_enable, DM_write, DM_address, DM_in,
    output ld_valid, ld_data, ld_done,
    input  IM_out, DM_out, ld_ready
  );

  modport slave (
    input  IM_enable, IM_address, IM_write,
    input  DM_enable, DM_write, DM_address, DM_in,
    input  ld_valid, ld_data, ld_done,
    output IM_out, DM_out, ld_ready
  );

endinterface

// File: rtl/cpu_mem_responder_mem_array_1w2r.sv
// Word array with one write port and two registered read ports.
// Reads see the array before the same-edge write (read-first).
module mem_array_1w2r
  import cpu_mem_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic              im_en,
  input  logic              im_clr,
  input  logic [AW-1:0]     im_addr,
  output logic [WORD_W-1:0] im_data,
  input  logic              dm_en,
  input  logic              dm_clr,
  input  logic [AW-1:0]     dm_addr,
  output logic [WORD_W-1:0] dm_data
);

  localparam int DEPTH = 1 << AW;

  logic [WORD_W-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto RAM and keeps loaded contents across rst.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // NOTE: non-blocking reads sample mem before this edge's write, giving read-first behaviour.
  always_ff @(posedge clk) begin
    if (!rst) begin
      im_data <= '0;
      dm_data <= '0;
    end else begin
      if (im_en) im_data <= im_clr ? '0 : mem[im_addr];
      if (dm_en) dm_data <= dm_clr ? '0 : mem[dm_addr];
    end
  end

endmodule

// File: rtl/cpu_mem_responder.sv
// Memory responder for the CPU instruction/data ports with a boot-load FSM.
// The CPU is held while the array is streamed in; afterwards IM/DM accesses are served.
module cpu_mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter bit INIT_HOLD  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  cpu_mem_if.slave          bus,
  output logic              cpu_hold,
  output logic              err,
  output logic [WORD_W-1:0] err_addr
);

  localparam logic [ADDR_WIDTH-1:0] PTR_MAX     = '1;
  localparam state_t                RESET_STATE = INIT_HOLD ? LOAD : RUN;

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] ld_ptr;
  logic                  ld_ready;

  logic                  run;
  logic                  im_req, im_ok, im_fault;
  logic                  dm_req, dm_ok, dm_fault;
  logic [ADDR_WIDTH-1:0] im_word, dm_word;
  logic                  load_we, dm_we, we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [WORD_W-1:0]     wdata;
  logic [WORD_W-1:0]     im_data, dm_data;

  // Address decode; requests only count once the CPU has been released.
  assign run      = (state == RUN);
  assign im_req   = run && bus.IM_enable;
  assign dm_req   = run && bus.DM_enable;
  assign im_ok    = in_range(bus.IM_address, ADDR_WIDTH);
  assign dm_ok    = in_range(bus.DM_address, ADDR_WIDTH);
  assign im_word  = ADDR_WIDTH'(word_index(bus.IM_address, ADDR_WIDTH));
  assign dm_word  = ADDR_WIDTH'(word_index(bus.DM_address, ADDR_WIDTH));
  assign im_fault = im_req && (!im_ok || bus.IM_write);
  assign dm_fault = dm_req && !dm_ok;

  // Single write port: the loader owns it in LOAD, the data port in RUN.
  assign load_we = (state == LOAD) && bus.ld_valid;
  assign dm_we   = dm_req && bus.DM_write && dm_ok;
  assign we      = load_we || dm_we;
  assign waddr   = load_we ? ld_ptr      : dm_word;
  assign wdata   = load_we ? bus.ld_data : bus.DM_in;

  always_ff @(posedge clk) begin
    if (!rst) state <= RESET_STATE;
    else      state <= state_n;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_n  = state;
    ld_ready = 1'b0;
    cpu_hold = 1'b0;
    case (state)
      LOAD: begin
        ld_ready = 1'b1;
        cpu_hold = 1'b1;
        if (bus.ld_done || (bus.ld_valid && ld_ptr == PTR_MAX)) state_n = RUN;
      end
      RUN: ;
      default: state_n = RESET_STATE;
    endcase
  end

  assign bus.ld_ready = ld_ready;

  // Pointer saturates at the last word; the FSM leaves LOAD on that word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ld_ptr <= '0;
    end else if (load_we && ld_ptr != PTR_MAX) begin
      ld_ptr <= ld_ptr + 1'b1;
    end
  end

  // Sticky error; the first offending address wins, IM before DM.
  always_ff @(posedge clk) begin
    if (!rst) begin
      err      <= 1'b0;
      err_addr <= '0;
    end else if (!err && (im_fault || dm_fault)) begin
      err      <= 1'b1;
      err_addr <= im_fault ? bus.IM_address : bus.DM_address;
    end
  end

  mem_array_1w2r #(
    .AW (ADDR_WIDTH)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .im_en   (im_req),
    .im_clr  (!im_ok),
    .im_addr (im_word),
    .im_data (im_data),
    .dm_en   (dm_req && !bus.DM_write),
    .dm_clr  (!dm_ok),
    .dm_addr (dm_word),
    .dm_data (dm_data)
  );

  assign bus.IM_out = im_data;
  assign bus.DM_out = dm_data;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed self-checking bench for cpu_mem_responder (ADDR_WIDTH=10 and a full-array ADDR_WIDTH=3 copy).
module tb_cpu_mem_responder;
  import cpu_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst, rst_s;
  logic        hold, hold_s;
  logic        err, err_s;
  logic [31:0] err_addr, err_addr_s;

  int checks = 0;
  int errors = 0;

  cpu_mem_if b ();
  cpu_mem_if s ();

  cpu_mem_responder #(.ADDR_WIDTH(10), .INIT_HOLD(1'b1)) dut (
    .clk (clk), .rst (rst), .bus (b.slave),
    .cpu_hold (hold), .err (err), .err_addr (err_addr)
  );

  cpu_mem_responder #(.ADDR_WIDTH(3), .INIT_HOLD(1'b1)) dut_s (
    .clk (clk), .rst (rst_s), .bus (s.slave),
    .cpu_hold (hold_s), .err (err_s), .err_addr (err_addr_s)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_b();
    b.IM_enable = 0; b.IM_address = 0; b.IM_write = 0;
    b.DM_enable = 0; b.DM_write = 0; b.DM_address = 0; b.DM_in = 0;
    b.ld_valid = 0; b.ld_data = 0; b.ld_done = 0;
  endtask

  task automatic idle_s();
    s.IM_enable = 0; s.IM_address = 0; s.IM_write = 0;
    s.DM_enable = 0; s.DM_write = 0; s.DM_address = 0; s.DM_in = 0;
    s.ld_valid = 0; s.ld_data = 0; s.ld_done = 0;
  endtask

  task automatic test_reset();
    idle_b(); idle_s();
    rst = 0; rst_s = 0;
    tick(); tick();
    checks++; if (b.IM_out !== 32'h0) begin errors++; $display("FAIL reset_im_out got %h exp %h", b.IM_out, 32'h0); end
    checks++; if (b.DM_out !== 32'h0) begin errors++; $display("FAIL reset_dm_out got %h exp %h", b.DM_out, 32'h0); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
    checks++; if (err_addr !== 32'h0) begin errors++; $display("FAIL reset_err_addr got %h exp 0", err_addr); end
    checks++; if (hold !== 1'b1 || b.ld_ready !== 1'b1) begin errors++; $display("FAIL reset_load_state hold %b ready %b exp 1 1", hold, b.ld_ready); end
    rst = 1; rst_s = 1;
  endtask

  task automatic test_reset_mid_load();
    logic [31:0] first [3]  = '{32'hA, 32'hB, 32'hC};
    logic [31:0] expv  [3]  = '{32'hD, 32'hE, 32'hC};
    for (int i = 0; i < 3; i++) begin
      b.ld_valid = 1; b.ld_data = first[i];
      // requests during LOAD must be ignored, including a misaligned one
      b.IM_enable = 1; b.IM_address = 32'h3;
      tick();
    end
    checks++; if (b.IM_out !== 32'h0 || err !== 1'b0) begin errors++; $display("FAIL load_ignores_im im_out %h err %b exp 0 0", b.IM_out, err); end
    idle_b();
    rst = 0; tick(); rst = 1;
    checks++; if (hold !== 1'b1) begin errors++; $display("FAIL midload_reset_hold got %b exp 1", hold); end
    b.ld_valid = 1; b.ld_data = 32'hD; tick();
    b.ld_data = 32'hE; tick();
    checks++; if (hold !== 1'b1) begin errors++; $display("FAIL midload_hold_before_done got %b exp 1", hold); end
    b.ld_valid = 0; b.ld_done = 1; tick();
    b.ld_done = 0;
    checks++; if (hold !== 1'b0) begin errors++; $display("FAIL midload_hold_after_done got %b exp 0", hold); end
    for (int i = 0; i < 3; i++) begin
      b.IM_enable = 1; b.IM_address = 32'(i * 4); tick();
      checks++; if (b.IM_out !== expv[i]) begin errors++; $display("FAIL midload_word%0d got %h exp %h", i, b.IM_out, expv[i]); end
    end
    idle_b();
  endtask

  task automatic test_load_run();
    logic [31:0] prog [4] = '{32'h00000013, 32'h00100093, 32'h00200113, 32'h00308193};
    rst = 0; tick(); rst = 1;
    for (int i = 0; i < 4; i++) begin
      b.ld_valid = 1; b.ld_data = prog[i]; b.ld_done = (i == 3);
      tick();
      if (i < 3) begin
        checks++; if (hold !== 1'b1) begin errors++; $display("FAIL load_hold_w%0d got %b exp 1", i, hold); end
      end
    end
    idle_b();
    checks++; if (hold !== 1'b0 || b.ld_ready !== 1'b0) begin errors++; $display("FAIL load_release hold %b ready %b exp 0 0", hold, b.ld_ready); end
    for (int i = 0; i < 4; i++) begin
      b.IM_enable = 1; b.IM_address = 32'(i * 4);
      #2;
      if (i > 0) begin
        checks++; if (b.IM_out !== prog[i-1]) begin errors++; $display("FAIL im_latency_w%0d got %h exp %h", i, b.IM_out, prog[i-1]); end
      end
      tick();
      checks++; if (b.IM_out !== prog[i]) begin errors++; $display("FAIL im_read_w%0d got %h exp %h", i, b.IM_out, prog[i]); end
    end
    b.IM_enable = 0; b.IM_address = 32'h0; tick();
    checks++; if (b.IM_out !== prog[3]) begin errors++; $display("FAIL im_hold got %h exp %h", b.IM_out, prog[3]); end
  endtask

  task automatic test_data_rw();
    b.DM_enable = 1; b.DM_write = 0; b.DM_address = 32'h4; tick();
    checks++; if (b.DM_out !== 32'h00100093) begin errors++; $display("FAIL dm_read_prog got %h exp %h", b.DM_out, 32'h00100093); end
    b.DM_write = 1; b.DM_address = 32'h40; b.DM_in = 32'hDEADBEEF; tick();
    checks++; if (b.DM_out !== 32'h00100093) begin errors++; $display("FAIL dm_hold_on_write got %h exp %h", b.DM_out, 32'h00100093); end
    b.DM_write = 0; b.DM_in = 0; tick();
    checks++; if (b.DM_out !== 32'hDEADBEEF) begin errors++; $display("FAIL dm_read_after_write got %h exp %h", b.DM_out, 32'hDEADBEEF); end
    b.DM_enable = 0; b.DM_address = 32'h4; tick();
    checks++; if (b.DM_out !== 32'hDEADBEEF) begin errors++; $display("FAIL dm_idle_hold got %h exp %h", b.DM_out, 32'hDEADBEEF); end
    idle_b();
  endtask

  task automatic test_collision();
    b.DM_enable = 1; b.DM_write = 1; b.DM_address = 32'h10; b.DM_in = 32'h11111111; tick();
    b.DM_in = 32'h22222222;
    b.IM_enable = 1; b.IM_address = 32'h10; tick();
    checks++; if (b.IM_out !== 32'h11111111) begin errors++; $display("FAIL collision_old got %h exp %h", b.IM_out, 32'h11111111); end
    b.DM_enable = 0; b.DM_write = 0; tick();
    checks++; if (b.IM_out !== 32'h22222222) begin errors++; $display("FAIL collision_new got %h exp %h", b.IM_out, 32'h22222222); end
    idle_b();
  endtask

  task automatic test_errors();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_before got %b exp 0", err); end
    b.DM_enable = 1; b.DM_write = 0; b.DM_address = 32'h00001002; tick();
    b.DM_enable = 0;
    checks++; if (err !== 1'b1 || err_addr !== 32'h00001002) begin errors++; $display("FAIL err_first err %b addr %h exp 1 %h", err, err_addr, 32'h00001002); end
    checks++; if (b.DM_out !== 32'h0) begin errors++; $display("FAIL err_dm_out got %h exp 0", b.DM_out); end
    tick();
    b.IM_enable = 1; b.IM_address = 32'h00010000; tick();
    b.IM_enable = 0;
    checks++; if (err_addr !== 32'h00001002) begin errors++; $display("FAIL err_first_wins got %h exp %h", err_addr, 32'h00001002); end
    checks++; if (b.IM_out !== 32'h0) begin errors++; $display("FAIL err_im_out got %h exp 0", b.IM_out); end
    // After reset, simultaneous IM and DM faults capture the IM address.
    idle_b();
    rst = 0; tick(); rst = 1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_cleared got %b exp 0", err); end
    b.ld_done = 1; tick(); b.ld_done = 0;
    b.IM_enable = 1; b.IM_address = 32'h3;
    b.DM_enable = 1; b.DM_address = 32'h5000; tick();
    idle_b();
    checks++; if (err !== 1'b1 || err_addr !== 32'h3) begin errors++; $display("FAIL err_im_priority err %b addr %h exp 1 %h", err, err_addr, 32'h3); end
  endtask

  task automatic test_full_array();
    for (int i = 0; i < 8; i++) begin
      s.ld_valid = 1; s.ld_data = 32'(i); tick();
      if (i < 7) begin
        checks++; if (hold_s !== 1'b1) begin errors++; $display("FAIL full_hold_w%0d got %b exp 1", i, hold_s); end
      end
    end
    checks++; if (hold_s !== 1'b0 || s.ld_ready !== 1'b0) begin errors++; $display("FAIL full_auto_run hold %b ready %b exp 0 0", hold_s, s.ld_ready); end
    s.ld_data = 32'h99; tick();
    idle_s();
    for (int i = 0; i < 8; i++) begin
      s.IM_enable = 1; s.IM_address = 32'(i * 4); tick();
      checks++; if (s.IM_out !== 32'(i)) begin errors++; $display("FAIL full_word%0d got %h exp %h", i, s.IM_out, 32'(i)); end
    end
    idle_s();
    checks++; if (err_s !== 1'b0) begin errors++; $display("FAIL full_err got %b exp 0", err_s); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_load();
    test_load_run();
    test_data_rw();
    test_collision();
    test_errors();
    test_full_array();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
